// File: rtl/bsg_rx.sv
// bsg_rx: serial frame receiver with a CONTROL/DATA_1/DATA_2 register bus.
// Deserializes 16-bit LSB-first frames into two byte registers and flags IRQ.
module bsg_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       SYS_CLK,
    input  logic       reset,
    input  logic       RX_IN,
    input  logic       valid,
    input  logic       write,
    input  logic [1:0] endereco,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       IRQ
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_D1   = 2'd1;
    localparam logic [1:0] A_D2   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // synchronizer and receive datapath
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [15:0]            shift_q, shift_d;
    logic                   frame_ok;
    logic                   frame_err;

    // register file
    logic       rxen_q, rxen_d;
    logic       intmsk_q, intmsk_d;
    logic       intflag_q, intflag_d;
    logic       overrun_q, overrun_d;
    logic       frameerr_q, frameerr_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;

    // bus side
    logic       ready_q, ready_d;
    logic [7:0] dout_q, dout_d;
    logic       access;
    logic       wr_ctrl;
    logic       rd_d2;
    logic [7:0] rdata;
    logic [7:0] ctrl_rd;
    logic       unused_bits;

    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign ready       = ready_q;
    assign data_out    = dout_q;
    assign IRQ         = intflag_q & intmsk_q;
    assign unused_bits = ^{data_in[7:6], data_in[3]};

    // RX_IN synchronizer shift chain, idles high
    always_ff @(posedge SYS_CLK) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
        end
    end

    // receive FSM next-state, bit timing and frame completion events
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (state_q != IDLE && !rxen_q) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            bit_idx_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rxen_q && !rx_s) begin
                        state_d   = START;
                        bit_cnt_d = '0;
                    end
                end
                START: begin
                    if (bit_cnt_q == CNT_HALF) begin
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d          = '0;
                        shift_d[bit_idx_q] = rx_s;
                        bit_idx_d          = bit_idx_q + 1'b1;
                        if (bit_idx_q == 4'd15) begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        frame_ok  = rx_s;
                        frame_err = !rx_s;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // receive FSM state, counters and shift register
    always_ff @(posedge SYS_CLK) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // bus decode, read mux and register next-state; hardware sets win
    always_comb begin
        access  = valid && !ready_q;
        wr_ctrl = access && write && (endereco == A_CTRL);
        rd_d2   = access && !write && (endereco == A_D2);
        ctrl_rd = {2'b00, frameerr_q, overrun_q,
                   (state_q != IDLE), intflag_q, intmsk_q, rxen_q};
        rdata   = 8'h00;
        unique case (endereco)
            A_CTRL:  rdata = ctrl_rd;
            A_D1:    rdata = data1_q;
            A_D2:    rdata = data2_q;
            default: rdata = 8'h00;
        endcase

        ready_d = access;
        dout_d  = (access && !write) ? rdata : 8'h00;

        rxen_d     = wr_ctrl ? data_in[0] : rxen_q;
        intmsk_d   = wr_ctrl ? data_in[1] : intmsk_q;
        intflag_d  = intflag_q;
        overrun_d  = overrun_q;
        frameerr_d = frameerr_q;
        data1_d    = data1_q;
        data2_d    = data2_q;

        if ((wr_ctrl && data_in[2]) || rd_d2) begin
            intflag_d = 1'b0;
        end
        if (wr_ctrl && data_in[4]) begin
            overrun_d = 1'b0;
        end
        if (wr_ctrl && data_in[5]) begin
            frameerr_d = 1'b0;
        end
        if (frame_ok) begin
            intflag_d = 1'b1;
            data1_d   = shift_q[7:0];
            data2_d   = shift_q[15:8];
            if (intflag_q) begin
                overrun_d = 1'b1;
            end
        end
        if (frame_err) begin
            frameerr_d = 1'b1;
        end
    end

    // register file and bus response registers
    always_ff @(posedge SYS_CLK) begin
        if (!reset) begin
            rxen_q     <= 1'b0;
            intmsk_q   <= 1'b0;
            intflag_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frameerr_q <= 1'b0;
            data1_q    <= 8'h00;
            data2_q    <= 8'h00;
            ready_q    <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            rxen_q     <= rxen_d;
            intmsk_q   <= intmsk_d;
            intflag_q  <= intflag_d;
            overrun_q  <= overrun_d;
            frameerr_q <= frameerr_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
        end
    end

endmodule

// File: tb/tb_bsg_rx.sv
// tb_bsg_rx: directed bench for bsg_rx.
// Register vectors from a table, frame scenarios as hand-written sequences.
module tb_bsg_rx;

    localparam int CPB = 16;

    logic       SYS_CLK;
    logic       reset;
    logic       RX_IN;
    logic       valid;
    logic       write;
    logic [1:0] endereco;
    logic [7:0] data_in;
    logic       ready;
    logic [7:0] data_out;
    logic       IRQ;

    int checks;
    int failures;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [12];

    bsg_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .RX_IN   (RX_IN),
        .valid   (valid),
        .write   (write),
        .endereco(endereco),
        .data_in (data_in),
        .ready   (ready),
        .data_out(data_out),
        .IRQ     (IRQ)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    // one bus access; called and returns on a negedge
    task automatic bus(input logic wr, input logic [1:0] a,
                       input logic [7:0] wd, output logic [7:0] rd);
        int n;
        valid    = 1'b1;
        write    = wr;
        endereco = a;
        data_in  = wd;
        n        = 0;
        do begin
            @(posedge SYS_CLK);
            @(negedge SYS_CLK);
            n++;
        end while (!ready && n < 8);
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout: got ready=0 expected ready=1");
        end
        rd    = data_out;
        valid = 1'b0;
        write = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a,
                          input logic [7:0] exp);
        logic [7:0] r;
        bus(1'b0, a, 8'h00, r);
        chk(nm, r, exp);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic line_bit(input logic b);
        RX_IN = b;
        repeat (CPB) @(negedge SYS_CLK);
    endtask

    task automatic send_frame(input logic [15:0] d, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 16; i++) line_bit(d[i]);
        line_bit(stop);
        RX_IN = 1'b1;
        repeat (3 * CPB) @(negedge SYS_CLK);
    endtask

    initial begin
        logic [7:0] r;
        logic [15:0] fr;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        RX_IN    = 1'b1;
        valid    = 1'b0;
        write    = 1'b0;
        endereco = 2'd0;
        data_in  = 8'h00;

        vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, "rst_ctrl"};
        vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h00, "rst_d1"};
        vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h00, "rst_d2"};
        vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, "rst_resv"};
        vecs[4]  = '{1'b1, 2'd3, 8'hFF, 8'h00, "wr_resv"};
        vecs[5]  = '{1'b0, 2'd3, 8'h00, 8'h00, "rd_resv"};
        vecs[6]  = '{1'b1, 2'd0, 8'hFF, 8'h00, "wr_ctrl_ff"};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 8'h03, "rd_ctrl_ff"};
        vecs[8]  = '{1'b1, 2'd0, 8'h00, 8'h00, "wr_ctrl_00"};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 8'h00, "rd_ctrl_00"};
        vecs[10] = '{1'b1, 2'd0, 8'h03, 8'h00, "wr_ctrl_03"};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 8'h03, "rd_ctrl_03"};

        repeat (3) @(negedge SYS_CLK);
        chk("rst_ready", {7'd0, ready}, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_irq", {7'd0, IRQ}, 8'h00);
        reset = 1'b1;
        @(negedge SYS_CLK);

        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r);
            chk(vecs[i].name, r, vecs[i].exp);
        end
        @(negedge SYS_CLK);
        chk("ready_pulse", {7'd0, ready}, 8'h00);
        chk("dout_idle", data_out, 8'h00);

        // good frame
        send_frame(16'hA53C, 1'b1);
        chk("a53c_irq", {7'd0, IRQ}, 8'h01);
        rd_chk("a53c_ctrl", 2'd0, 8'h07);
        rd_chk("a53c_d1", 2'd1, 8'h3C);
        rd_chk("a53c_d2", 2'd2, 8'hA5);
        rd_chk("a53c_ctrl_clr", 2'd0, 8'h03);
        chk("a53c_irq_clr", {7'd0, IRQ}, 8'h00);

        // 6-cycle glitch on the line
        RX_IN = 1'b0;
        repeat (4) @(negedge SYS_CLK);
        rd_chk("glitch_status", 2'd0, 8'h0B);
        @(negedge SYS_CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge SYS_CLK);
        rd_chk("glitch_ctrl", 2'd0, 8'h03);
        rd_chk("glitch_d1", 2'd1, 8'h3C);

        // framing error
        send_frame(16'h1234, 1'b0);
        rd_chk("ferr_ctrl", 2'd0, 8'h23);
        rd_chk("ferr_d1", 2'd1, 8'h3C);
        rd_chk("ferr_d2", 2'd2, 8'hA5);
        wr_reg(2'd0, 8'h23);
        rd_chk("ferr_clr", 2'd0, 8'h03);

        // overrun
        send_frame(16'h00FF, 1'b1);
        send_frame(16'hBEEF, 1'b1);
        chk("ovr_irq", {7'd0, IRQ}, 8'h01);
        rd_chk("ovr_ctrl", 2'd0, 8'h17);
        rd_chk("ovr_d1", 2'd1, 8'hEF);
        rd_chk("ovr_d2", 2'd2, 8'hBE);
        rd_chk("ovr_after_d2", 2'd0, 8'h13);
        wr_reg(2'd0, 8'h13);
        rd_chk("ovr_clr", 2'd0, 8'h03);

        // disable in the middle of data bit 7
        fr = 16'h5AA5;
        line_bit(1'b0);
        for (int i = 0; i < 7; i++) line_bit(fr[i]);
        RX_IN = fr[7];
        repeat (8) @(negedge SYS_CLK);
        rd_chk("dis_busy", 2'd0, 8'h0B);
        wr_reg(2'd0, 8'h02);
        rd_chk("dis_idle", 2'd0, 8'h02);
        RX_IN = 1'b1;
        repeat (3 * CPB) @(negedge SYS_CLK);
        rd_chk("dis_ctrl", 2'd0, 8'h02);
        rd_chk("dis_d1", 2'd1, 8'hEF);
        wr_reg(2'd0, 8'h03);
        send_frame(16'h5AA5, 1'b1);
        rd_chk("re_ctrl", 2'd0, 8'h07);
        rd_chk("re_d1", 2'd1, 8'hA5);
        chk("re_irq", {7'd0, IRQ}, 8'h01);

        // reset during data bit 10
        fr = 16'h0F0F;
        line_bit(1'b0);
        for (int i = 0; i < 10; i++) line_bit(fr[i]);
        RX_IN = fr[10];
        repeat (4) @(negedge SYS_CLK);
        reset = 1'b0;
        @(negedge SYS_CLK);
        chk("mrst_ready", {7'd0, ready}, 8'h00);
        chk("mrst_dout", data_out, 8'h00);
        chk("mrst_irq", {7'd0, IRQ}, 8'h00);
        reset = 1'b1;
        repeat (CPB - 5) @(negedge SYS_CLK);
        for (int i = 11; i < 16; i++) line_bit(fr[i]);
        line_bit(1'b1);
        repeat (3 * CPB) @(negedge SYS_CLK);
        rd_chk("mrst_ctrl", 2'd0, 8'h00);
        rd_chk("mrst_d1", 2'd1, 8'h00);
        rd_chk("mrst_d2", 2'd2, 8'h00);
        chk("mrst_irq_end", {7'd0, IRQ}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
